// File: rtl/sim_verdict_pkg.sv
// Shared encodings for the simulation verdict controller: FSM states,
// report status codes and the packed report layout.
package sim_verdict_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_FAIL    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam int REP_STATUS_LSB  = 30;
  localparam int REP_STATUS_W    = 2;
  localparam int REP_IDX_LSB     = 24;
  localparam int REP_IDX_W       = 6;
  localparam int REP_CODE_LSB    = 16;
  localparam int REP_CODE_W      = 8;
  localparam int REP_ELAPSED_LSB = 0;
  localparam int REP_ELAPSED_W   = 16;

  function automatic logic [31:0] pack_report(input logic [REP_STATUS_W-1:0]  status,
                                              input logic [REP_IDX_W-1:0]     idx,
                                              input logic [REP_CODE_W-1:0]    code,
                                              input logic [REP_ELAPSED_W-1:0] elapsed);
    return {status, idx, code, elapsed};
  endfunction

endpackage

// File: rtl/sim_chan_tracker.sv
// One checker channel: sticky first-done capture of fail flag and code.
// The *_o outputs are the post-latch view so the top can decide on this cycle.
module sim_chan_tracker #(
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              done_i,
  input  logic              fail_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              done_o,
  output logic              fail_o,
  output logic [CODE_W-1:0] code_o
);

  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [CODE_W-1:0] code_q, code_d;

  always_comb begin
    done_d = done_q;
    fail_d = fail_q;
    code_d = code_q;
    if (clr_i) begin
      done_d = 1'b0;
      fail_d = 1'b0;
      code_d = '0;
    end else if (en_i && done_i && !done_q) begin
      done_d = 1'b1;
      fail_d = fail_i;
      code_d = code_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      code_q <= '0;
    end else begin
      done_q <= done_d;
      fail_q <= fail_d;
      code_q <= code_d;
    end
  end

  assign done_o = done_d;
  assign fail_o = fail_d;
  assign code_o = code_d;

endmodule

// File: rtl/sim_verdict.sv
// Simulation verdict controller: tracks checker channels, runs a watchdog and
// emits a registered report word plus sticky pass/fail verdicts.
module sim_verdict
  import sim_verdict_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int CODE_W         = 8,
  parameter int REPORT_W       = 32
) (
  input  logic                         refclk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CHANNELS-1:0]          chan_done,
  input  logic [CHANNELS-1:0]          chan_fail,
  input  logic [CHANNELS*CODE_W-1:0]   chan_code,
  output logic                         busy,
  output logic                         report_valid,
  output logic [REPORT_W-1:0]          sim_report,
  output logic                         sim_success,
  output logic                         sim_failure,
  output logic [1:0]                   dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (CODE_W != 8) begin : g_bad_code_w
    $error("sim_verdict: CODE_W must be 8");
  end
  if (REPORT_W != 32) begin : g_bad_report_w
    $error("sim_verdict: REPORT_W must be 32");
  end
  if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
    $error("sim_verdict: CHANNELS must be 1..64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sim_verdict: TIMEOUT_CYCLES must be >= 2");
  end

  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       busy_q, report_valid_q, success_q, failure_q;
  logic [31:0]                report_q;

  logic                       start_ok, trk_en;
  logic [CHANNELS-1:0]        done_d, fail_d;
  logic [CHANNELS*CODE_W-1:0] code_d;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign trk_en   = (state_q == S_RUN);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    sim_chan_tracker #(.CODE_W(CODE_W)) u_trk (
      .clk    (refclk),
      .rst_n  (rst_n),
      .clr_i  (start_ok),
      .en_i   (trk_en),
      .done_i (chan_done[g]),
      .fail_i (chan_fail[g]),
      .code_i (chan_code[g*CODE_W +: CODE_W]),
      .done_o (done_d[g]),
      .fail_o (fail_d[g]),
      .code_o (code_d[g*CODE_W +: CODE_W])
    );
  end

  // Lowest-index encoders: descending loop so the last hit is the lowest index.
  logic       fail_any, all_done;
  logic [5:0] fail_idx, nd_idx;
  logic [7:0] fail_code;

  always_comb begin
    fail_any  = 1'b0;
    fail_idx  = '0;
    fail_code = '0;
    nd_idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (fail_d[i]) begin
        fail_any  = 1'b1;
        fail_idx  = 6'(i);
        fail_code = code_d[i*CODE_W +: 8];
      end
      if (!done_d[i]) nd_idx = 6'(i);
    end
    all_done = &done_d;
  end

  logic [31:0] cnt_ext;
  logic [15:0] elapsed;
  assign cnt_ext = 32'(cnt_q);
  assign elapsed = (cnt_ext >= 32'h0000_FFFF) ? 16'hFFFF : 16'(cnt_ext + 32'd1);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      report_valid_q <= 1'b0;
      success_q      <= 1'b0;
      failure_q      <= 1'b0;
      report_q       <= '0;
    end else begin
      report_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            success_q <= 1'b0;
            failure_q <= 1'b0;
            report_q  <= '0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (fail_any) begin
            report_q       <= pack_report(ST_FAIL, fail_idx, fail_code, elapsed);
            report_valid_q <= 1'b1;
            state_q        <= S_REPORT;
          end else if (all_done) begin
            report_q       <= pack_report(ST_PASS, 6'd0, 8'd0, elapsed);
            report_valid_q <= 1'b1;
            state_q        <= S_REPORT;
          end else if (cnt_q == CNT_LAST) begin
            report_q       <= pack_report(ST_TIMEOUT, nd_idx, 8'd0, elapsed);
            report_valid_q <= 1'b1;
            state_q        <= S_REPORT;
          end
        end
        S_REPORT: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          if (report_q[REP_STATUS_LSB +: REP_STATUS_W] == ST_PASS) success_q <= 1'b1;
          else                                                      failure_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign report_valid = report_valid_q;
  assign sim_report   = report_q;
  assign sim_success  = success_q;
  assign sim_failure  = failure_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sim_verdict.sv
// Bench for sim_verdict: directed scenarios plus randomized channel schedules
// checked against an event-level reference model; a second instance covers elapsed saturation.
module tb_sim_verdict;

  localparam int CH     = 4;
  localparam int TO     = 100;
  localparam int TO_SAT = 70000;

  // clock / reset
  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 refclk = ~refclk;

  logic            start = 1'b0;
  logic [CH-1:0]   chan_done = '0;
  logic [CH-1:0]   chan_fail = '0;
  logic [CH*8-1:0] chan_code = '0;
  logic            busy, report_valid, sim_success, sim_failure;
  logic [31:0]     sim_report;
  logic [1:0]      dbg_state;

  sim_verdict #(.CHANNELS(CH), .TIMEOUT_CYCLES(TO), .CODE_W(8), .REPORT_W(32)) u_dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .start        (start),
    .chan_done    (chan_done),
    .chan_fail    (chan_fail),
    .chan_code    (chan_code),
    .busy         (busy),
    .report_valid (report_valid),
    .sim_report   (sim_report),
    .sim_success  (sim_success),
    .sim_failure  (sim_failure),
    .dbg_state    (dbg_state)
  );

  logic            s_start = 1'b0;
  logic [CH-1:0]   s_zero = '0;
  logic [CH*8-1:0] s_zero_code = '0;
  logic            s_busy, s_rv, s_succ, s_fail;
  logic [31:0]     s_rep;
  logic [1:0]      s_state;

  sim_verdict #(.CHANNELS(CH), .TIMEOUT_CYCLES(TO_SAT), .CODE_W(8), .REPORT_W(32)) u_sat (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .start        (s_start),
    .chan_done    (s_zero),
    .chan_fail    (s_zero),
    .chan_code    (s_zero_code),
    .busy         (s_busy),
    .report_valid (s_rv),
    .sim_report   (s_rep),
    .sim_success  (s_succ),
    .sim_failure  (s_fail),
    .dbg_state    (s_state)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one run's schedule: RUN cycle of first done (-1 never), optional later duplicate
  int         done_cyc[CH];
  int         dup_cyc[CH];
  logic       fail_b[CH];
  logic [7:0] code_b[CH];
  bit         noise;
  bit         start_noise;

  task automatic clear_case();
    for (int i = 0; i < CH; i++) begin
      done_cyc[i] = -1;
      dup_cyc[i]  = -1;
      fail_b[i]   = 1'b0;
      code_b[i]   = 8'h00;
    end
    noise       = 1'b0;
    start_noise = 1'b0;
  endtask

  // Reference: exit cycle is the earliest of first failing done, last done, or TO-1.
  function automatic logic [31:0] model();
    int         t_exit = TO - 1;
    int         last = -1;
    bit         all = 1'b1;
    logic [1:0] st;
    int         idx = 0;
    logic [7:0] code = 8'h00;
    bit         found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (done_cyc[i] >= 0 && fail_b[i] && done_cyc[i] < t_exit) t_exit = done_cyc[i];
      if (done_cyc[i] < 0) all = 1'b0;
      else if (done_cyc[i] > last) last = done_cyc[i];
    end
    if (all && last < t_exit) t_exit = last;
    for (int i = 0; i < CH && !found; i++)
      if (done_cyc[i] >= 0 && done_cyc[i] <= t_exit && fail_b[i]) begin
        found = 1'b1; idx = i; code = code_b[i];
      end
    if (found) st = 2'b10;
    else begin
      st = 2'b01;
      for (int i = CH - 1; i >= 0; i--)
        if (done_cyc[i] < 0 || done_cyc[i] > t_exit) begin
          st = 2'b11; idx = i;
        end
    end
    return {st, 6'(idx), code, 16'(t_exit + 1)};
  endfunction

  // driver
  task automatic drive(input int k);
    for (int i = 0; i < CH; i++) begin
      if (k == done_cyc[i]) begin
        chan_done[i] = 1'b1; chan_fail[i] = fail_b[i]; chan_code[i*8 +: 8] = code_b[i];
      end else if (k == dup_cyc[i]) begin
        chan_done[i] = 1'b1; chan_fail[i] = 1'($urandom); chan_code[i*8 +: 8] = 8'($urandom);
      end else begin
        chan_done[i] = 1'b0;
        chan_fail[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        chan_code[i*8 +: 8] = 8'($urandom);
      end
    end
    start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic idle_inputs();
    chan_done = '0; chan_fail = '0; chan_code = '0; start = 1'b0;
  endtask

  task automatic run_case();
    logic [31:0] exp;
    int          k = 0;
    bit          timed = 1'b0;
    exp = exp_q.pop_front();
    start = 1'b1;
    @(posedge refclk); #1;
    start = 1'b0;
    check("busy_on_start", busy, 1);
    check("verdict_cleared", {sim_success, sim_failure}, 0);
    check("report_cleared", sim_report, 0);
    while (!report_valid) begin
      if (k > TO + 2) begin timed = 1'b1; break; end
      drive(k);
      @(posedge refclk); #1;
      k++;
    end
    idle_inputs();
    check("report_valid_wait", report_valid, 1);
    if (!timed) begin
      check("sim_report", sim_report, exp);
      check("exit_latency", k, 32'(exp[15:0]));
      check("busy_in_report", busy, 1);
      @(posedge refclk); #1;
      check("report_valid_pulse", report_valid, 0);
      check("report_held", sim_report, exp);
      check("verdict", {sim_success, sim_failure}, (exp[31:30] == 2'b01) ? 32'd2 : 32'd1);
      check("busy_in_done", busy, 0);
    end
  endtask

  bit sat_go = 1'b0;
  bit sat_done = 1'b0;

  initial begin : sat_proc
    int n = 0;
    wait (sat_go);
    @(posedge refclk); #1;
    s_start = 1'b1;
    @(posedge refclk); #1;
    s_start = 1'b0;
    while (!s_rv && n < TO_SAT + 10) begin
      @(posedge refclk); #1;
      n++;
    end
    check("sat_report_valid", s_rv, 1);
    check("sat_report", s_rep, 32'hC000_FFFF);
    @(posedge refclk); #1;
    check("sat_verdict", {s_succ, s_fail}, 1);
    sat_done = 1'b1;
  end

  initial begin : main_proc
    int n = 0;
    clear_case();
    repeat (3) @(posedge refclk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_report_valid", report_valid, 0);
    check("rst_report", sim_report, 0);
    check("rst_verdict", {sim_success, sim_failure}, 0);
    check("rst_state", dbg_state, 0);
    @(negedge refclk) rst_n = 1'b1;

    // staggered clean completion, with start noise during RUN
    clear_case();
    done_cyc = '{10, 20, 30, 40};
    start_noise = 1'b1;
    exp_q.push_back(32'h4000_0029);
    run_case();

    // fail on ch2 after a clean ch1
    clear_case();
    done_cyc[1] = 2; done_cyc[2] = 5; fail_b[2] = 1'b1; code_b[2] = 8'hA5;
    exp_q.push_back(32'h82A5_0006);
    run_case();

    // simultaneous fails, lowest index wins
    clear_case();
    done_cyc[3] = 0; fail_b[3] = 1'b1; code_b[3] = 8'h11;
    done_cyc[1] = 0; fail_b[1] = 1'b1; code_b[1] = 8'h22;
    exp_q.push_back(32'h8122_0001);
    run_case();

    // ch0 never done -> timeout
    clear_case();
    done_cyc = '{-1, 3, 4, 5};
    exp_q.push_back(32'hC000_0064);
    run_case();

    // completion on the timeout cycle beats timeout
    clear_case();
    done_cyc = '{99, 3, 4, 5};
    exp_q.push_back(32'h4000_0064);
    run_case();

    // duplicate done with fail after a clean done is ignored
    clear_case();
    done_cyc = '{5, 12, 7, 9};
    dup_cyc[0] = 8;
    noise = 1'b1;
    exp_q.push_back(32'h4000_000D);
    run_case();

    // reset while holding a DONE verdict
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_verdict", {sim_success, sim_failure}, 0);
    check("rst_done_report", sim_report, 0);
    check("rst_done_state", dbg_state, 0);
    @(negedge refclk) rst_n = 1'b1;

    // reset mid-RUN aborts without a report
    clear_case();
    done_cyc[0] = 1;
    start = 1'b1;
    @(posedge refclk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(k);
      @(posedge refclk); #1;
    end
    check("run_state_before_rst", dbg_state, 1);
    #2 rst_n = 1'b0;
    #1;
    idle_inputs();
    check("rst_run_busy", busy, 0);
    check("rst_run_state", dbg_state, 0);
    check("rst_run_outputs", {report_valid, sim_success, sim_failure}, 0);
    @(negedge refclk) rst_n = 1'b1;
    @(posedge refclk); #1;
    check("idle_after_rst", dbg_state, 0);
    check("no_report_after_rst", report_valid, 0);

    sat_go = 1'b1;

    // randomized schedules
    for (int r = 0; r < 150; r++) begin
      clear_case();
      for (int i = 0; i < CH; i++) begin
        done_cyc[i] = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 105);
        fail_b[i]   = ($urandom_range(0, 3) == 0);
        code_b[i]   = 8'($urandom);
        if (done_cyc[i] >= 0 && $urandom_range(0, 3) == 0)
          dup_cyc[i] = done_cyc[i] + $urandom_range(1, 10);
      end
      noise       = 1'($urandom_range(0, 1));
      start_noise = 1'($urandom_range(0, 1));
      exp_q.push_back(model());
      run_case();
      repeat ($urandom_range(0, 3)) @(posedge refclk);
      #1;
    end

    while (!sat_done && n < 80000) begin
      @(posedge refclk);
      n++;
    end
    if (!sat_done) check("sat_finished", 32'(sat_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sim_verdict.md
Name: sim_verdict

Overview:
- Parametrised simulation verdict controller. Used by the testbench template family as the common source of `sim_success`, `sim_failure` and `sim_report`, replacing per-bench ad-hoc end conditions and the fixed `$finish` timeout.
- Tracks CHANNELS independent checker channels, each reporting done/fail with a code.
- Applies a cycle-accurate watchdog.
- Emits one packed report word plus a sticky pass/fail verdict.
- Synthesisable RTL, so the same block can also run on hardware self-test builds.

Parameters:
- CHANNELS, 4, number of checker channels (1..64).
- TIMEOUT_CYCLES, 800000, number of RUN cycles before a timeout verdict (>=2).
- CODE_W, 8, per-channel fail code width (fixed 8 in report layout; other values rejected at elaboration).
- REPORT_W, 32, report word width (fixed 32; other values rejected at elaboration).

Ports:
- refclk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled in IDLE/DONE.
- chan_done  in  CHANNELS  per-channel completion strobe.
- chan_fail  in  CHANNELS  failure flag, valid only with chan_done.
- chan_code  in  CHANNELS*8  failure code; channel i at [8i+7:8i], valid with chan_done.
- busy  out  1  high in RUN and REPORT.
- report_valid  out  1  one-cycle strobe qualifying sim_report.
- sim_report  out  32  packed verdict word (layout below).
- sim_success  out  1  sticky pass verdict.
- sim_failure  out  1  sticky fail or timeout verdict.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; all trackers and counter cleared. Reset mid-RUN aborts with no report.
- States: IDLE, RUN, REPORT, DONE.
- IDLE: start=1 -> RUN next cycle; counter=0; trackers cleared.
- RUN: counter increments every cycle, starting at 0 on the first RUN cycle.
- RUN, per channel: the first chan_done latches done_seen, fail_seen=chan_fail and code. Later chan_done on that channel is ignored. chan_fail without chan_done is ignored.
- RUN, start is ignored.
- RUN exit conditions are evaluated on the post-latch tracker state in the same cycle, in this priority order:
  - (1) any fail_seen -> status FAIL; idx = lowest failing channel; code = that channel's code.
  - (2) all done_seen -> status PASS; idx=0; code=0.
  - (3) counter == TIMEOUT_CYCLES-1 -> status TIMEOUT; idx = lowest channel without done_seen; code=0.
- Any exit -> REPORT. Completion therefore beats timeout on the same cycle, and fail beats all-done.
- Elapsed = number of RUN cycles including the exit cycle (counter+1), saturated at 0xFFFF.
- sim_report layout:
  - [31:30] status: 01 PASS, 10 FAIL, 11 TIMEOUT.
  - [29:24] idx.
  - [23:16] code.
  - [15:0] elapsed.
- REPORT (1 cycle): report_valid=1; sim_report is registered and stays stable until the next run starts.
- REPORT -> DONE: sim_success=1 if PASS, else sim_failure=1. Both are never high together.
- DONE: verdict and sim_report are held. start=1 -> both verdicts cleared, report cleared to 0, trackers and counter cleared, -> RUN.
- Counter width is clog2(TIMEOUT_CYCLES+1). The elapsed field uses a separate 16-bit saturating counter, or a clamped copy of the counter.
- No combinational path from inputs to outputs; all outputs registered.

Decomposition:
- Package sim_verdict_pkg holds:
  - status encodings (ST_PASS=2'b01, ST_FAIL=2'b10, ST_TIMEOUT=2'b11);
  - state enum;
  - report field offsets/widths.
- Sub-module sim_chan_tracker holds one channel's sticky done/fail/code, with a clear input. It is instantiated CHANNELS times via generate.
- The lowest-index priority encoders (fail and not-done) stay in the top.

Test Plan:
- CHANNELS=4: start; ch0..ch3 done (no fail) at RUN cycles 10, 20, 30, 40 -> report_valid in the cycle after RUN cycle 40; sim_report=0x4000_0029; then sim_success=1, sim_failure=0, busy=0.
- ch1 done no-fail at cycle 2; ch2 done with fail, code 0xA5 at cycle 5 -> sim_report=0x82A5_0006; sim_failure=1.
- ch3 fail code 0x11 and ch1 fail code 0x22 on RUN cycle 0 -> sim_report=0x8122_0001 (lowest index wins).
- TIMEOUT_CYCLES=100; ch1..ch3 done, ch0 never -> exit on RUN cycle 99; sim_report=0xC000_0064; sim_failure=1.
  - Variant: ch0 done on cycle 99 -> PASS, 0x4000_0064.
- Control and reset:
  - start pulsed mid-RUN -> no effect.
  - Duplicate chan_done on ch0 with fail after a clean done -> ignored, PASS.
  - rst_n low mid-RUN -> all outputs 0 asynchronously; IDLE after release.
  - start in DONE -> verdicts clear the next cycle and a new run completes normally.
- Saturation: TIMEOUT_CYCLES=70000, no channel done -> sim_report=0xC000_FFFF.
